dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder that sits on the far side of the CPU's MEM-stage load/store port. It accepts one word request at a time (read or write) and completes it after a fixed, parameterised latency. It returns read data plus an error flag for misaligned or out-of-range addresses. It drives a stall back to the pipeline so MEM holds its instruction until the access completes.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 32-bit words, byte-addressed, with word accesses only.
- `LATENCY`, default 2: cycles from accept to response. Must be at least 1.

- `clk_i`, in, 1: the single clock; all state updates on the rising edge.
- `rst_i`, in, 1: synchronous reset, active-high.
- `req_valid_i`, in, 1: request present. The CPU holds it and all `req_*` fields stable until `resp_valid_o` is seen.
- `req_write_i`, in, 1: 1 = store, 0 = load.
- `req_addr_i`, in, 32: byte address.
- `req_wdata_i`, in, 32: store data.
- `req_ready_o`, out, 1: high only in IDLE.
- `resp_valid_o`, out, 1: one-cycle completion pulse.
- `resp_rdata_o`, out, 32: load data. It is 0 for stores and for errors, and holds its value between responses.
- `resp_err_o`, out, 1: error flag, valid while `resp_valid_o` is high and held afterwards.
- `stall_o`, out, 1: combinational, `req_valid_i & ~resp_valid_o`.

## Operation
- States are IDLE, WAIT and RESP, held in a state register.
- IDLE:
  - If `req_valid_i` is high, capture addr, wdata and write into internal registers.
  - Compute err = (addr[1:0] != 0) or (addr[31:DEPTH_LOG2+2] != 0), and capture it.
  - Go to WAIT with counter = LATENCY-1 when LATENCY > 1; go straight to RESP when LATENCY == 1.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next edge enters RESP.
- Entry into RESP (on that same edge):
  - If err: no memory access, rdata = 0, err = 1.
  - Else if write: mem[addr[DEPTH_LOG2+1:2]] = wdata, rdata = 0, err = 0.
  - Else (read): rdata = mem[index], err = 0.
- RESP: `resp_valid_o` is high for exactly this one cycle, then the block returns unconditionally to IDLE.
- Requests are never accepted in WAIT or RESP. Changes on `req_*` during those states are ignored, because the captured copy is used.
- Width rules:
  - Word index = addr[DEPTH_LOG2+1:2].
  - The address is never truncated silently: any set bit above DEPTH_LOG2+1 is an error.
  - The counter is wide enough for LATENCY (clog2(LATENCY+1) bits).
- Memory contents are not reset and are undefined until written. A bench must write before it reads.
- Reset (any state, including mid-operation):
  - Next state is IDLE, and a pending write is dropped with no memory update.
  - Reset values: `req_ready_o`=1, `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, counter 0. `stall_o` follows `req_valid_i`.

## Timing
- Accept edge: the edge at the end of cycle N with IDLE & `req_valid_i`.
- `resp_valid_o` is high in cycle N+LATENCY.
- Throughput: one request per LATENCY+1 cycles, because RESP always returns to IDLE before the next accept.
- `stall_o` is high in cycles N..N+LATENCY-1 and low in cycle N+LATENCY. This lets the pipeline advance on that cycle's edge.
- A write is visible to a read accepted in the cycle after RESP or later.
- `req_valid_i` low in IDLE: the block stays in IDLE with no outputs changing. This is the idle and bubble case, and `stall_o` is 0.
- `rst_i` in the same cycle as an accept condition: reset wins and nothing is captured.

## Test plan
- LATENCY=2, write 0xDEADBEEF to 0x10 with accept in cycle 0:
  - Required: `resp_valid_o`=1 in cycle 2, `resp_err_o`=0, `resp_rdata_o`=0.
  - Follow with a read of 0x10: `resp_rdata_o`=0xDEADBEEF two cycles after its accept.
- Misaligned read of 0x13 after writing 0x11111111 to 0x10:
  - Required: `resp_err_o`=1, `resp_rdata_o`=0.
  - A following read of 0x10 still returns 0x11111111.
- Out-of-range write of 0x400 with DEPTH_LOG2=8:
  - Required: `resp_err_o`=1.
  - Reads of 0x000 and 0x3FC are unchanged from their prior values.
- `req_valid_i` held high for two back-to-back requests (LATENCY=2):
  - Required: accepts at cycles 0 and 3, `resp_valid_o` pulses in cycles 2 and 5.
  - `stall_o` is low only in cycles 2 and 5 while `req_valid_i` is high.
- Reset mid-operation: write 0x5A5A5A5A to 0x20 (previously 0x12345678), then pulse `rst_i` in cycle 1 of WAIT:
  - Required: no `resp_valid_o` pulse.
  - Outputs return to their reset values.
  - A subsequent read of 0x20 returns 0x12345678.
- LATENCY=1, read of 0x04 accepted in cycle 0:
  - Required: `resp_valid_o` in cycle 1, the block is in IDLE in cycle 2, and `req_ready_o`=0 only in cycle 1.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store request/response bundle between CPU and data memory
//   req_valid/req_write/req_addr/req_wdata : request, held stable by the CPU until resp_valid
//   req_ready                               : responder can accept (IDLE)
//   resp_valid/resp_rdata/resp_err          : one-cycle completion pulse with load data and error flag
//   stall                                   : hold MEM while a request is outstanding
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word data memory answering one load/store at a time after LATENCY cycles
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : dmem_responder_if slave (request in, response/ready/stall out)
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  dmem_responder_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [DEPTH_LOG2-1:0] idx_q, op_idx;
  logic [31:0]           wdata_q, op_wdata, rdata_q;
  logic                  write_q, err_q, op_write, op_err, live_err, accept, to_resp, resp_err_q;
  logic [31:0]           mem [2**DEPTH_LOG2];
  // With LATENCY==1 the accept edge is also the RESP entry edge, so the live request feeds the access.
  always_comb begin
    live_err  = (|bus.req_addr[1:0]) || (|bus.req_addr[31:DEPTH_LOG2+2]);
    accept    = state == IDLE && bus.req_valid;
    op_idx    = accept ? bus.req_addr[DEPTH_LOG2+1:2] : idx_q;
    op_wdata  = accept ? bus.req_wdata : wdata_q;
    op_write  = accept ? bus.req_write : write_q;
    op_err    = accept ? live_err : err_q;
    state_nxt = state == IDLE ? (bus.req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt == CW'(1) ? RESP : WAIT) : IDLE;
    to_resp   = state_nxt == RESP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= accept ? CW'(LATENCY - 1) : state == WAIT ? cnt - CW'(1) : cnt;
      if (accept) begin
        idx_q   <= bus.req_addr[DEPTH_LOG2+1:2];
        wdata_q <= bus.req_wdata;
        write_q <= bus.req_write;
        err_q   <= live_err;
      end
      if (to_resp) begin
        rdata_q    <= (op_err || op_write) ? '0 : mem[op_idx];
        resp_err_q <= op_err;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i && to_resp && op_write && !op_err) mem[op_idx] <= op_wdata;
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.stall      = bus.req_valid & ~bus.resp_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, corner sequences and randomized traffic against a word-array model
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_responder_if ifa ();
  dmem_responder_if ifb ();
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  int checks = 0;
  int failures = 0;
  logic [31:0] mdl [256];
  bit vld [256];
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
    bit          hold;
  } vec_t;
  vec_t tbl [13];
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endfunction
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic e, output logic [31:0] rd);
    e  = (a % 4 != 0) || (a >= 1024);
    rd = '0;
    if (!e && !w) rd = mdl[a / 4];
    if (!e && w) begin
      mdl[a / 4] = d;
      vld[a / 4] = 1'b1;
    end
  endfunction
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input bit hold,
                      output logic [31:0] rd, output logic e);
    bit got = 1'b0;
    rd = '0;
    e  = 1'b0;
    ifa.req_valid = 1'b1;
    ifa.req_write = w;
    ifa.req_addr  = a;
    ifa.req_wdata = d;
    #1;
    chk("acc_ready", ifa.req_ready, 1);
    chk("acc_stall", ifa.stall, 1);
    for (int k = 1; k <= LAT + 2 && !got; k++) begin
      @(negedge clk);
      if (ifa.resp_valid) begin
        got = 1'b1;
        chk("resp_cycle", k, LAT);
        chk("resp_stall", ifa.stall, 0);
        chk("resp_ready", ifa.req_ready, 0);
        rd = ifa.resp_rdata;
        e  = ifa.resp_err;
      end else begin
        chk("wait_stall", ifa.stall, 1);
        chk("wait_ready", ifa.req_ready, 0);
      end
    end
    if (!got) chk("timeout", 0, 1);
    if (!hold) ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", ifa.req_ready, 1);
    chk("idle_valid", ifa.resp_valid, 0);
    if (!hold) chk("bubble_stall", ifa.stall, 0);
  endtask
  initial begin
    logic [31:0] rd, mrd, a, d;
    logic e, me, w;
    int idx, kind;
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", ifa.req_ready, 1);
    chk("rst_valid_a", ifa.resp_valid, 0);
    chk("rst_rdata_a", ifa.resp_rdata, 0);
    chk("rst_err_a", ifa.resp_err, 0);
    chk("rst_ready_b", ifb.req_ready, 1);
    chk("rst_valid_b", ifb.resp_valid, 0);
    ifa.req_valid = 1'b1;
    #1;
    chk("rst_stall_follow", ifa.stall, 1);
    ifa.req_valid = 1'b0;
    #1;
    chk("rst_stall_low", ifa.stall, 0);
    rst = 1'b0;
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,       32'h11111111, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h13,       32'h0,        1'b1, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'h11111111, 1'b0};
    tbl[5]  = '{1'b1, 32'h000,      32'hA0A0A0A0, 1'b0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h3FC,      32'hC3C3C3C3, 1'b0, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h400,      32'h77777777, 1'b1, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h000,      32'h0,        1'b0, 32'hA0A0A0A0, 1'b0};
    tbl[9]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 32'hC3C3C3C3, 1'b0};
    tbl[10] = '{1'b0, 32'h80000010, 32'h0,        1'b1, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 32'h3FE,      32'h99999999, 1'b1, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h10,       32'h0,        1'b0, 32'h11111111, 1'b0};
    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, me, mrd);
      xact(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold, rd, e);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end
    model(1'b1, 32'h20, 32'h12345678, me, mrd);
    xact(1'b1, 32'h20, 32'h12345678, 1'b0, rd, e);
    xact(1'b0, 32'h20, 32'h0, 1'b0, rd, e);
    chk("pre_rst_read", rd, 32'h12345678);
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h20; ifa.req_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("mid_wait_valid", ifa.resp_valid, 0);
    rst = 1'b1;
    ifa.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ifa.resp_valid, 0);
    chk("mid_rst_ready", ifa.req_ready, 1);
    chk("mid_rst_rdata", ifa.resp_rdata, 0);
    chk("mid_rst_err", ifa.resp_err, 0);
    chk("mid_rst_stall", ifa.stall, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_resp", ifa.resp_valid, 0);
    end
    xact(1'b0, 32'h20, 32'h0, 1'b0, rd, e);
    chk("mid_read_kept", rd, 32'h12345678);
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h20; ifa.req_wdata = 32'hFFFF0000;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc_ready", ifa.req_ready, 1);
    ifa.req_valid = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_acc_no_resp", ifa.resp_valid, 0);
    end
    xact(1'b0, 32'h20, 32'h0, 1'b0, rd, e);
    chk("rst_acc_kept", rd, 32'h12345678);
    ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_addr = 32'h04; ifb.req_wdata = 32'hCAFEF00D;
    #1;
    chk("l1_w_ready0", ifb.req_ready, 1);
    chk("l1_w_stall0", ifb.stall, 1);
    @(negedge clk);
    chk("l1_w_valid1", ifb.resp_valid, 1);
    chk("l1_w_ready1", ifb.req_ready, 0);
    chk("l1_w_err1", ifb.resp_err, 0);
    chk("l1_w_stall1", ifb.stall, 0);
    ifb.req_valid = 1'b0;
    @(negedge clk);
    chk("l1_w_valid2", ifb.resp_valid, 0);
    chk("l1_w_ready2", ifb.req_ready, 1);
    ifb.req_valid = 1'b1; ifb.req_write = 1'b0; ifb.req_addr = 32'h04; ifb.req_wdata = 32'h0;
    @(negedge clk);
    chk("l1_r_valid1", ifb.resp_valid, 1);
    chk("l1_r_ready1", ifb.req_ready, 0);
    chk("l1_r_rdata1", ifb.resp_rdata, 32'hCAFEF00D);
    ifb.req_valid = 1'b0;
    @(negedge clk);
    chk("l1_r_valid2", ifb.resp_valid, 0);
    chk("l1_r_ready2", ifb.req_ready, 1);
    chk("l1_r_hold2", ifb.resp_rdata, 32'hCAFEF00D);
    for (int n = 0; n < 60; n++) begin
      idx  = $urandom_range(0, 255);
      kind = $urandom_range(0, 9);
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      a    = idx * 4;
      if (kind == 0) a = a + $urandom_range(1, 3);
      if (kind == 1) a = a | (32'h1 << $urandom_range(10, 31));
      if (kind > 1 && !w && !vld[idx]) w = 1'b1;
      model(w, a, d, me, mrd);
      xact(w, a, d, (n != 59) && ($urandom_range(0, 1) == 1), rd, e);
      chk("rnd_err", e, me);
      chk("rnd_rdata", rd, mrd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
